// File: rtl/pattern_delay_timer.sv
// Serial-start delay timer: hunts for a start pattern, shifts in a delay,
// counts (delay+1)*TICKS_PER_UNIT cycles, then holds done until ack/abort.
module pattern_delay_timer #(
  parameter int                   PATTERN_W      = 4,
  parameter logic [PATTERN_W-1:0] PATTERN        = 4'b1101,
  parameter int                   DELAY_W        = 4,
  parameter int                   TICKS_PER_UNIT = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data,
  input  logic               ack,
  input  logic               abort,
  output logic [DELAY_W-1:0] count,
  output logic               counting,
  output logic               done,
  output logic               busy
);

  localparam int HW = PATTERN_W - 1;
  localparam int SW = $clog2(PATTERN_W + 1);
  localparam int TW = $clog2(TICKS_PER_UNIT);
  localparam int BW = $clog2(DELAY_W) + 1;

  localparam logic [SW-1:0] SEEN_MAX  = SW'(PATTERN_W);
  localparam logic [SW-1:0] SEEN_ARM  = SW'(PATTERN_W - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_UNIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DELAY_W - 1);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_SHIFT,
    S_COUNT,
    S_WAIT
  } state_t;

  state_t r_state;
  state_t w_next;

  // Only PATTERN_W-1 past bits matter; the live bit completes the window.
  logic [HW-1:0]        r_hist;
  logic [SW-1:0]        r_seen;
  logic [BW-1:0]        r_bit;
  logic [DELAY_W-1:0]   r_delay;
  logic [TW-1:0]        r_tick;

  logic [PATTERN_W-1:0] w_hcat;
  logic                 w_match;
  logic                 w_wrap;
  logic                 w_clear;

  assign w_hcat  = {r_hist, data};
  assign w_match = (w_hcat == PATTERN) && (r_seen >= SEEN_ARM);
  assign w_wrap  = (r_tick == TICK_LAST);
  assign w_clear = (w_next == S_SEARCH) && (r_state != S_SEARCH);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_SEARCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_SEARCH: begin
        if (w_match) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (abort)                w_next = S_SEARCH;
        else if (r_bit == BIT_LAST) w_next = S_COUNT;
      end
      S_COUNT: begin
        if (abort)                          w_next = S_SEARCH;
        else if (w_wrap && (r_delay == '0)) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (ack || abort) w_next = S_SEARCH;
      end
      default: w_next = S_SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || w_clear) begin
      r_hist  <= '0;
      r_seen  <= '0;
      r_bit   <= '0;
      r_delay <= '0;
      r_tick  <= '0;
    end else begin
      unique case (r_state)
        S_SEARCH: begin
          r_hist <= w_hcat[HW-1:0];
          r_bit  <= '0;
          if (r_seen != SEEN_MAX) r_seen <= r_seen + SW'(1);
        end
        S_SHIFT: begin
          r_delay <= DELAY_W'({r_delay, data});
          r_bit   <= r_bit + BW'(1);
          r_tick  <= '0;
        end
        S_COUNT: begin
          if (w_wrap) begin
            r_tick <= '0;
            if (r_delay != '0) r_delay <= r_delay - DELAY_W'(1);
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    count    = r_delay;
    counting = 1'b0;
    done     = 1'b0;
    busy     = 1'b0;
    unique case (r_state)
      S_SHIFT: busy = 1'b1;
      S_COUNT: begin
        counting = 1'b1;
        busy     = 1'b1;
      end
      S_WAIT:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
